// File: rtl/kernel_load_seq_pkg.sv
// Shared definitions for the kernel loader and the PE grid that consumes its rows.
package kernel_load_seq_pkg;

    localparam int DW_DEFAULT = 16;
    localparam int TAG_ROW_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        ISSUE,
        DONE
    } state_t;

    // Width of a counter able to index n items; never narrower than one bit.
    function automatic int col_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/kernel_load_seq_rd_tag_pipe.sv
// Tracks which column each in-flight BRAM read belongs to, delayed by the BRAM latency.
module rd_tag_pipe #(
    parameter int RD_LAT = 2,
    parameter int TW     = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    output logic [TW-1:0] out_tag
);

    logic [RD_LAT-1:0]         vld;
    logic [RD_LAT-1:0][TW-1:0] tag;

    // Shift the valid/tag pair one stage per cycle; reset drops every in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            tag <= '0;
        end else begin
            vld[0] <= in_valid;
            tag[0] <= in_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                vld[i] <= vld[i-1];
                tag[i] <= tag[i-1];
            end
        end
    end

    assign out_valid = vld[RD_LAT-1];
    assign out_tag   = tag[RD_LAT-1];

endmodule

// File: rtl/kernel_load_seq.sv
// Loads a KROWS x KCOLS kernel from BRAM one row at a time and hands each row to the PE grid.
module kernel_load_seq
    import kernel_load_seq_pkg::*;
#(
    parameter int DW        = DW_DEFAULT,
    parameter int KROWS     = 6,
    parameter int KCOLS     = 6,
    parameter int GRID_COLS = 14,
    parameter int AW        = 5,
    parameter int RD_LAT    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [AW-1:0]           base_addr,
    output logic                    busy,
    output logic                    done,
    output logic [AW-1:0]           bram_addr,
    input  logic [DW-1:0]           bram_dout,
    output logic [GRID_COLS*DW-1:0] row_weight_vals,
    output logic [TAG_ROW_W-1:0]    tag_row,
    output logic                    valid_y,
    input  logic                    grid_ready
);

    localparam int                   CW         = col_width(KCOLS);
    localparam logic [CW-1:0]        LAST_COL   = CW'(KCOLS - 1);
    localparam logic [TAG_ROW_W-1:0] LAST_ROW   = TAG_ROW_W'(KROWS - 1);
    localparam logic [AW-1:0]        ROW_STRIDE = AW'(KCOLS);

    state_t                   state;
    state_t                   next_state;
    logic [TAG_ROW_W-1:0]     row;
    logic [CW-1:0]            col;
    logic [AW-1:0]            row_base;
    logic [AW-1:0]            last_addr;
    logic [AW-1:0]            cur_addr;
    logic                     fetch_en;
    logic                     rd_valid;
    logic [CW-1:0]            rd_tag;
    logic [KCOLS-1:0][DW-1:0] row_buf;

    assign cur_addr = row_base + AW'(col);
    assign tag_row  = row;

    rd_tag_pipe #(
        .RD_LAT (RD_LAT),
        .TW     (CW)
    ) u_rd_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (fetch_en),
        .in_tag    (col),
        .out_valid (rd_valid),
        .out_tag   (rd_tag)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and the state-derived outputs.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        valid_y    = 1'b0;
        fetch_en   = 1'b0;
        bram_addr  = last_addr;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                busy      = 1'b1;
                fetch_en  = 1'b1;
                bram_addr = cur_addr;
                if (col == LAST_COL) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (rd_valid && (rd_tag == LAST_COL)) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                busy    = 1'b1;
                valid_y = 1'b1;
                if (grid_ready) begin
                    next_state = (row == LAST_ROW) ? DONE : FETCH;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Row/column counters and the held read address; row_base tracks base + r*KCOLS modulo 2^AW.
    always_ff @(posedge clk) begin
        if (rst) begin
            row       <= '0;
            col       <= '0;
            row_base  <= '0;
            last_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        row_base <= base_addr;
                        row      <= '0;
                        col      <= '0;
                    end
                end
                FETCH: begin
                    last_addr <= cur_addr;
                    col       <= (col == LAST_COL) ? '0 : col + CW'(1);
                end
                ISSUE: begin
                    if (grid_ready && (row != LAST_ROW)) begin
                        row      <= row + TAG_ROW_W'(1);
                        row_base <= row_base + ROW_STRIDE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Steer each returning read word into the column its tag names.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_buf <= '0;
        end else if (rd_valid) begin
            row_buf[rd_tag] <= bram_dout;
        end
    end

    // Live kernel columns come from the row buffer; grid columns beyond the kernel read zero.
    for (genvar c = 0; c < GRID_COLS; c++) begin : g_col
        if (c < KCOLS) begin : g_live
            assign row_weight_vals[c*DW +: DW] = row_buf[c];
        end else begin : g_zero
            assign row_weight_vals[c*DW +: DW] = '0;
        end
    end

endmodule

// File: tb/tb_kernel_load_seq.sv
// Self-checking bench for kernel_load_seq: default build plus RD_LAT=1 and RD_LAT=3 builds.
module tb_kernel_load_seq;

    localparam int DW = 16;
    localparam int GC = 14;
    localparam int VW = GC * DW;

    typedef struct packed {
        logic [3:0]    tag;
        logic [VW-1:0] vals;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [4:0]    base_addr;
    logic          busy;
    logic          done;
    logic [4:0]    bram_addr;
    logic [DW-1:0] bram_dout;
    logic [VW-1:0] row_weight_vals;
    logic [3:0]    tag_row;
    logic          valid_y;
    logic          grid_ready;

    logic          start_v;
    logic [4:0]    base_v = 5'd0;
    logic          gr_v   = 1'b1;
    logic          busy1, done1, vy1, busy3, done3, vy3;
    logic [4:0]    addr1, addr3;
    logic [DW-1:0] dout1, dout3;
    logic [VW-1:0] vals1, vals3;
    logic [3:0]    tag1, tag3;

    logic [4:0]    a2 [2];
    logic [4:0]    a1;
    logic [4:0]    a3 [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q3[$];
    exp_t e0, e1, e3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    kernel_load_seq dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .busy(busy), .done(done),
        .bram_addr(bram_addr), .bram_dout(bram_dout), .row_weight_vals(row_weight_vals),
        .tag_row(tag_row), .valid_y(valid_y), .grid_ready(grid_ready)
    );

    kernel_load_seq #(.RD_LAT(1)) dut_lat1 (
        .clk(clk), .rst(rst), .start(start_v), .base_addr(base_v), .busy(busy1), .done(done1),
        .bram_addr(addr1), .bram_dout(dout1), .row_weight_vals(vals1),
        .tag_row(tag1), .valid_y(vy1), .grid_ready(gr_v)
    );

    kernel_load_seq #(.RD_LAT(3)) dut_lat3 (
        .clk(clk), .rst(rst), .start(start_v), .base_addr(base_v), .busy(busy3), .done(done3),
        .bram_addr(addr3), .bram_dout(dout3), .row_weight_vals(vals3),
        .tag_row(tag3), .valid_y(vy3), .grid_ready(gr_v)
    );

    // BRAM models holding BRAM[i] = i+1, each with its build's read latency.
    always @(posedge clk) begin
        a2[0] <= bram_addr;
        a2[1] <= a2[0];
        a1    <= addr1;
        a3[0] <= addr3;
        a3[1] <= a3[0];
        a3[2] <= a3[1];
    end
    assign bram_dout = DW'(a2[1]) + 16'd1;
    assign dout1     = DW'(a1) + 16'd1;
    assign dout3     = DW'(a3[2]) + 16'd1;

    function automatic logic [VW-1:0] exp_row(input int base, input int r);
        logic [VW-1:0] v;
        v = '0;
        for (int c = 0; c < 6; c++) begin
            v[c*DW +: DW] = DW'(((base + r * 6 + c) % 32) + 1);
        end
        return v;
    endfunction

    task automatic push_main(input int base);
        exp_t e;
        for (int r = 0; r < 6; r++) begin
            e.tag  = 4'(r);
            e.vals = exp_row(base, r);
            q0.push_back(e);
        end
    endtask

    // Scoreboard for the default build: pop one expected row per grid handshake.
    always @(negedge clk) begin
        #1;
        if (!rst && valid_y && grid_ready) begin
            n_vec++;
            if (q0.size() == 0) begin
                n_err++;
                $display("[TB] FAIL row_main: unexpected row tag %0d vals %h", tag_row, row_weight_vals);
            end else begin
                e0 = q0.pop_front();
                if (tag_row !== e0.tag || row_weight_vals !== e0.vals) begin
                    n_err++;
                    $display("[TB] FAIL row_main: got tag %0d vals %h, required tag %0d vals %h",
                             tag_row, row_weight_vals, e0.tag, e0.vals);
                end
            end
        end
    end

    // Scoreboards for the RD_LAT=1 and RD_LAT=3 builds.
    always @(negedge clk) begin
        #1;
        if (!rst && vy1) begin
            n_vec++;
            if (q1.size() == 0) begin
                n_err++;
                $display("[TB] FAIL row_lat1: unexpected row tag %0d", tag1);
            end else begin
                e1 = q1.pop_front();
                if (tag1 !== e1.tag || vals1 !== e1.vals) begin
                    n_err++;
                    $display("[TB] FAIL row_lat1: got tag %0d vals %h, required tag %0d vals %h",
                             tag1, vals1, e1.tag, e1.vals);
                end
            end
        end
        if (!rst && vy3) begin
            n_vec++;
            if (q3.size() == 0) begin
                n_err++;
                $display("[TB] FAIL row_lat3: unexpected row tag %0d", tag3);
            end else begin
                e3 = q3.pop_front();
                if (tag3 !== e3.tag || vals3 !== e3.vals) begin
                    n_err++;
                    $display("[TB] FAIL row_lat3: got tag %0d vals %h, required tag %0d vals %h",
                             tag3, vals3, e3.tag, e3.vals);
                end
            end
        end
    end

    task automatic test_reset();
        rst        = 1'b1;
        start      = 1'b0;
        start_v    = 1'b0;
        base_addr  = 5'd0;
        grid_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || valid_y !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_ctrl: busy %b done %b valid_y %b, required 0 0 0", busy, done, valid_y);
        end
        n_vec++;
        if (tag_row !== 4'd0 || bram_addr !== 5'd0) begin
            n_err++;
            $display("[TB] FAIL reset_tag_addr: tag_row %0d bram_addr %0d, required 0 0", tag_row, bram_addr);
        end
        n_vec++;
        if (row_weight_vals !== '0) begin
            n_err++;
            $display("[TB] FAIL reset_vals: got %h, required 0", row_weight_vals);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_load();
        int n;
        push_main(0);
        base_addr = 5'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL basic_busy: got %b, required 1", busy);
        end
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (n != 55) begin
            n_err++;
            $display("[TB] FAIL basic_latency: done at cycle %0d, required 55", n);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL basic_done_pulse: done %b busy %b after pulse, required 0 0", done, busy);
        end
        n_vec++;
        if (q0.size() != 0) begin
            n_err++;
            $display("[TB] FAIL basic_rows: %0d rows outstanding, required 0", q0.size());
        end
    endtask

    task automatic test_backpressure();
        int n;
        push_main(0);
        base_addr = 5'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (tag_row !== 4'd2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        grid_ready = 1'b0;
        while (valid_y !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if (valid_y !== 1'b1 || tag_row !== 4'd2 || bram_addr !== 5'd17 || row_weight_vals !== exp_row(0, 2)) begin
                n_err++;
                $display("[TB] FAIL stall_hold %0d: valid_y %b tag %0d addr %0d vals %h, required 1 2 17 %h",
                         i, valid_y, tag_row, bram_addr, row_weight_vals, exp_row(0, 2));
            end
            @(negedge clk);
            n++;
        end
        grid_ready = 1'b1;
        while (done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (n != 65) begin
            n_err++;
            $display("[TB] FAIL stall_latency: done at cycle %0d, required 65", n);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int n;
        push_main(30);
        base_addr = 5'd30;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (bram_addr !== 5'((30 + i) % 32)) begin
                n_err++;
                $display("[TB] FAIL wrap_addr %0d: got %0d, required %0d", i, bram_addr, (30 + i) % 32);
            end
            @(negedge clk);
            n++;
        end
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (n != 55) begin
            n_err++;
            $display("[TB] FAIL wrap_latency: done at cycle %0d, required 55", n);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        int dones;
        push_main(0);
        base_addr = 5'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (tag_row !== 4'd3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q0.delete();
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || valid_y !== 1'b0 || tag_row !== 4'd0 || bram_addr !== 5'd0) begin
            n_err++;
            $display("[TB] FAIL midreset_outputs: busy %b done %b valid_y %b tag %0d addr %0d, required 0 0 0 0 0",
                     busy, done, valid_y, tag_row, bram_addr);
        end
        n_vec++;
        if (row_weight_vals !== '0) begin
            n_err++;
            $display("[TB] FAIL midreset_vals: got %h, required 0", row_weight_vals);
        end
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        n_vec++;
        if (dones != 0 || row_weight_vals !== '0) begin
            n_err++;
            $display("[TB] FAIL midreset_quiet: %0d busy/done cycles, vals %h, required 0 and 0", dones, row_weight_vals);
        end
        push_main(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (n != 55) begin
            n_err++;
            $display("[TB] FAIL midreset_restart: done at cycle %0d, required 55", n);
        end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int dones;
        int first;
        push_main(5);
        base_addr = 5'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        first = 0;
        for (int n = 1; n <= 150; n++) begin
            if (done === 1'b1) begin
                dones++;
                if (first == 0) first = n;
            end
            start     = (n == 10 || n == 40);
            base_addr = (n == 10 || n == 40) ? 5'd20 : 5'd5;
            @(negedge clk);
        end
        start = 1'b0;
        n_vec++;
        if (dones != 1 || first != 55) begin
            n_err++;
            $display("[TB] FAIL busy_start: %0d done pulses first at %0d, required 1 at 55", dones, first);
        end
        n_vec++;
        if (q0.size() != 0) begin
            n_err++;
            $display("[TB] FAIL busy_rows: %0d rows outstanding, required 0", q0.size());
        end
    endtask

    task automatic test_latency_variants();
        exp_t e;
        int n1;
        int n3;
        for (int r = 0; r < 6; r++) begin
            e.tag  = 4'(r);
            e.vals = exp_row(0, r);
            q1.push_back(e);
            q3.push_back(e);
        end
        start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
        n1 = 0;
        n3 = 0;
        for (int n = 1; n < 200 && (n1 == 0 || n3 == 0); n++) begin
            if (done1 === 1'b1 && n1 == 0) n1 = n;
            if (done3 === 1'b1 && n3 == 0) n3 = n;
            @(negedge clk);
        end
        n_vec++;
        if (n1 != 49) begin
            n_err++;
            $display("[TB] FAIL lat1_latency: done at cycle %0d, required 49", n1);
        end
        n_vec++;
        if (n3 != 61) begin
            n_err++;
            $display("[TB] FAIL lat3_latency: done at cycle %0d, required 61", n3);
        end
        @(negedge clk);
        n_vec++;
        if (q1.size() != 0 || q3.size() != 0) begin
            n_err++;
            $display("[TB] FAIL variant_rows: %0d and %0d rows outstanding, required 0 and 0", q1.size(), q3.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_start_while_busy();
        test_latency_variants();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
